mips_multiciclo_control: RTL and testbench

Multi-cycle MIPS control FSM. Sequences the shared datapath (PC, IR, register file, ALU, memory port and immediate extender) through fetch/decode/execute/writeback. It also configures the immediate extender: ext_sel selects the zero-extended immediate (ANDI/ORI) or the sign-extended immediate (ADDI/LW/SW/BEQ). Sits beside the datapath; all datapath write enables and mux selects come from this block.

---
 rtl/mips_ctrl_pkg.sv | 53 +++++
 rtl/mips_alu_decoder.sv | 44 ++++
 rtl/mips_multiciclo_control.sv | 158 +++++++++++++++
 tb/tb_mips_multiciclo_control.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control slice
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_IMMEX   = 4'd9;
  localparam logic [3:0] S_IMMWB   = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ASB_REGB  = 2'b00;
  localparam logic [1:0] ASB_FOUR  = 2'b01;
  localparam logic [1:0] ASB_IMM   = 2'b10;
  localparam logic [1:0] ASB_SHIFT = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  // ALU operation class requested by the FSM; the decoder resolves the final code
  localparam logic [1:0] CLS_ADD   = 2'd0;
  localparam logic [1:0] CLS_SUB   = 2'd1;
  localparam logic [1:0] CLS_FUNCT = 2'd2;
  localparam logic [1:0] CLS_IMM   = 2'd3;

endpackage

// File: rtl/mips_alu_decoder.sv
// rtl/mips_alu_decoder.sv - resolves ALU op class, opcode and funct into alu_control and ext_sel
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] cls,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       ext_sel
);

  always_comb begin
    alu_control = ALU_ADD;
    ext_sel     = 1'b0;
    case (cls)
      CLS_SUB: alu_control = ALU_SUB;
      CLS_FUNCT: begin
        // unknown funct falls back to ADD silently
        case (funct)
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      CLS_IMM: begin
        case (op)
          OP_ANDI: begin
            alu_control = ALU_AND;
            ext_sel     = 1'b1;
          end
          OP_ORI: begin
            alu_control = ALU_OR;
            ext_sel     = 1'b1;
          end
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multiciclo_control.sv
// rtl/mips_multiciclo_control.sv - multi-cycle MIPS control FSM; MEM_WAIT_EN adds mem_ready stalls
module mips_multiciclo_control
  import mips_ctrl_pkg::*;
#(
  parameter int ALUCTL_W = 3,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                zero,
`ifdef MEM_WAIT_EN
  input  logic                mem_ready,
`endif
  output logic                pc_en,
  output logic                i_or_d,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_src,
  output logic                ext_sel,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic                illegal_op,
  output logic [STATE_W-1:0]  estado
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               pc_write, branch, rdy;
  logic [1:0]         cls;

`ifdef MEM_WAIT_EN
  assign rdy = mem_ready;
`else
  assign rdy = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    pc_write   = 1'b0;
    branch     = 1'b0;
    i_or_d     = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = ASB_REGB;
    pc_src     = PCS_ALU;
    cls        = CLS_ADD;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write  = rdy;
        pc_write  = rdy;
        alu_src_b = ASB_FOUR;
        state_d   = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = ASB_SHIFT;
        case (op)
          OP_LW, OP_SW:              state_d = S_MEMADR;
          OP_RTYPE:                  state_d = S_RTYPEEX;
          OP_BEQ:                    state_d = S_BEQEX;
          OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_IMMEX;
          OP_J:                      state_d = S_JEX;
          default:                   illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = ASB_IMM;
        state_d   = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        i_or_d  = 1'b1;
        state_d = rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        state_d   = rdy ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alu_src_a = 1'b1;
        cls       = CLS_FUNCT;
        state_d   = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BEQEX: begin
        alu_src_a = 1'b1;
        cls       = CLS_SUB;
        pc_src    = PCS_ALUOUT;
        branch    = 1'b1;
      end
      S_IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = ASB_IMM;
        cls       = CLS_IMM;
        state_d   = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write = 1'b1;
        cls       = CLS_IMM;
      end
      S_JEX: begin
        pc_src   = PCS_JUMP;
        pc_write = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    // reset overrides the FETCH decode so no write escapes while it is held
    if (reset) begin
      pc_write   = 1'b0;
      branch     = 1'b0;
      i_or_d     = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = ASB_REGB;
      pc_src     = PCS_ALU;
      cls        = CLS_ADD;
      illegal_op = 1'b0;
    end
    pc_en = pc_write | (branch & zero);
  end

  mips_alu_decoder u_alu_decoder (
    .cls         (cls),
    .op          (op),
    .funct       (funct),
    .alu_control (alu_control),
    .ext_sel     (ext_sel)
  );

  assign estado = state_q;

endmodule

// File: tb/tb_mips_multiciclo_control.sv
// tb/tb_mips_multiciclo_control.sv - randomized instruction-level check of mips_multiciclo_control
module tb_mips_multiciclo_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       rdy;
  logic       pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, ext_sel, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [3:0] estado;
  logic [16:0] got_v;

  int n_tests = 0;
  int n_fail  = 0;
  int seq[$];

  always #5 clk = ~clk;

  mips_multiciclo_control dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct       (funct),
    .zero        (zero),
`ifdef MEM_WAIT_EN
    .mem_ready   (rdy),
`endif
    .pc_en       (pc_en),
    .i_or_d      (i_or_d),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .pc_src      (pc_src),
    .ext_sel     (ext_sel),
    .alu_control (alu_control),
    .illegal_op  (illegal_op),
    .estado      (estado)
  );

  assign got_v = {pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                  alu_src_a, alu_src_b, pc_src, ext_sel, alu_control, illegal_op};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] o);
    return o inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B};
  endfunction

  // Instruction -> list of states it walks through (without stalls)
  task automatic build_seq(input logic [5:0] o);
    seq = {0, 1};
    case (o)
      6'h23:               seq = {seq, 2, 3, 4};
      6'h2B:               seq = {seq, 2, 5};
      6'h00:               seq = {seq, 6, 7};
      6'h04:               seq = {seq, 8};
      6'h08, 6'h0C, 6'h0D: seq = {seq, 9, 10};
      6'h02:               seq = {seq, 11};
      default:             ;
    endcase
  endtask

  function automatic logic [16:0] exp_out(input int st, input logic [5:0] o, input logic [5:0] f,
                                          input logic z, input logic r);
    logic pw = 0, br = 0, iod = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, asa = 0, ext = 0, ill = 0;
    logic [1:0] asb = 0, pcs = 0;
    logic [2:0] alu = 3'b010;
    logic [2:0] imm_alu;
    logic       imm_ext;
    imm_alu = (o == 6'h0C) ? 3'b000 : (o == 6'h0D) ? 3'b001 : 3'b010;
    imm_ext = (o == 6'h0C) || (o == 6'h0D);
    case (st)
      0:  begin irw = r; pw = r; asb = 2'b01; end
      1:  begin asb = 2'b11; ill = !is_legal(o); end
      2:  begin asa = 1; asb = 2'b10; end
      3:  iod = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin iod = 1; mw = 1; end
      6:  begin
            asa = 1;
            alu = (f == 6'h22) ? 3'b110 : (f == 6'h24) ? 3'b000 :
                  (f == 6'h25) ? 3'b001 : (f == 6'h2A) ? 3'b111 : 3'b010;
          end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; alu = 3'b110; pcs = 2'b01; br = 1; end
      9:  begin asa = 1; asb = 2'b10; alu = imm_alu; ext = imm_ext; end
      10: begin rw = 1; alu = imm_alu; ext = imm_ext; end
      11: begin pcs = 2'b10; pw = 1; end
      default: ;
    endcase
    return {pw | (br & z), iod, mw, irw, rd, m2r, rw, asa, asb, pcs, ext, alu, ill};
  endfunction

  // Called at a negedge; ends at a negedge. zmode 0/1 fixes zero, 2 randomizes it.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode,
                           input int fetch_stall, input bit rnd_rdy);
    int idx = 0;
    int guard = 0;
    int st;
    build_seq(o);
    while (idx < seq.size()) begin
      st    = seq[idx];
      op    = o;
      funct = f;
      zero  = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      rdy   = 1'b1;
`ifdef MEM_WAIT_EN
      if (st == 0 && fetch_stall > 0) begin
        rdy = 1'b0;
        fetch_stall--;
      end else if (rnd_rdy && (st == 0 || st == 3 || st == 5)) begin
        rdy = ($urandom_range(0, 2) != 0);
      end
`endif
      #1;
      check($sformatf("estado op=%02h step=%0d", o, idx), 32'(estado), 32'(st));
      check($sformatf("outs op=%02h f=%02h st=%0d", o, f, st), 32'(got_v),
            32'(exp_out(st, o, f, zero, rdy)));
      if (!((st == 0 || st == 3 || st == 5) && !rdy)) idx++;
      @(negedge clk);
      guard++;
      if (guard > 40) begin
        check("cycle_budget", 32'(guard), 32'd40);
        idx = seq.size();
      end
    end
  endtask

  logic [5:0] legal_ops [8] = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B};
  logic [5:0] functs [6]    = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h11};

  initial begin
    logic [5:0] o;
    reset = 1'b1;
    op    = 6'h00;
    funct = 6'h00;
    zero  = 1'b0;
    rdy   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_outs", 32'(got_v), 32'h00004);
    check("rst_estado", 32'(estado), 32'd0);
    reset = 1'b0;

    run_instr(6'h23, 6'h00, 2, 0, 0);
    run_instr(6'h0D, 6'h00, 2, 0, 0);
    run_instr(6'h08, 6'h00, 2, 0, 0);
    run_instr(6'h0C, 6'h00, 2, 0, 0);
    run_instr(6'h04, 6'h00, 1, 0, 0);
    run_instr(6'h04, 6'h00, 0, 0, 0);
    run_instr(6'h00, 6'h2A, 2, 0, 0);
    run_instr(6'h00, 6'h3B, 2, 0, 0);
    run_instr(6'h3F, 6'h00, 2, 0, 0);
    run_instr(6'h02, 6'h00, 2, 0, 0);
    run_instr(6'h2B, 6'h00, 2, 3, 0);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        o = 6'($urandom);
        if (is_legal(o)) o = 6'h3F;
      end else begin
        o = legal_ops[$urandom_range(0, 7)];
      end
      run_instr(o, functs[$urandom_range(0, 5)], 2, 0, 1);
    end

    // async reset while sitting in MEMWR
    op = 6'h2B;
    repeat (3) @(negedge clk);
    #1;
    check("memwr_reached", 32'(estado), 32'd5);
    check("memwr_write", 32'(mem_write), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_mw", 32'(mem_write), 32'd0);
    check("rst_async_estado", 32'(estado), 32'd0);
    check("rst_async_outs", 32'(got_v), 32'h00004);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_estado", 32'(estado), 32'd0);
    @(posedge clk);
    #1;
    check("post_rst_decode", 32'(estado), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
